mmio_responder: RTL and testbench
=================================

# mmio_responder

Memory-mapped I/O responder for the 16-bit processor's data-memory port. It decodes data-bus accesses to the I/O page (0xFFF0–0xFFFF) and returns read data for those addresses. It synchronizes and debounces the KEY and SW board inputs and tracks change events in sticky status registers. It also holds the HEX/LEDR/LEDG output registers written by stores. It sits beside the memory array, and the processor muxes `RDATA` in whenever `SEL` is high.

## Interface
- `DBITS`, 16, data/address width; only 16 is supported.
- `DEBOUNCE_CYCLES`, 10, number of consecutive stable synchronized samples required to accept an input change; must be ≥1.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RESET_N`  in  1  reset, asynchronous and active-low.
- `ADDR`  in  16  data-bus byte address; bit 0 is ignored.
- `WDATA`  in  16  store data.
- `WE`  in  1  store strobe; the write commits at the next rising edge when `SEL` is high.
- `RE`  in  1  load strobe; qualifies read side effects only.
- `RDATA`  out  16  read data, combinational from `ADDR`.
- `SEL`  out  1  high when `ADDR[15:4]==12'hFFF`.
- `IRQ`  out  1  interrupt request, registered-state combinational.
- `KEY`  in  4  raw board keys, active-low (0 = pressed), asynchronous.
- `SW`  in  10  raw board switches, asynchronous.
- `HEXOUT`  out  16  value shown on the four seven-segment digits.
- `LEDR`  out  10  red LEDs.
- `LEDG`  out  8  green LEDs.

## Operation
- Register map (word addresses):
  - 0xFFF0 KDATA (RO): [3:0] debounced pressed state, 1 = pressed; upper bits read 0.
  - 0xFFF2 SDATA (RO): [9:0] debounced switches; upper bits read 0.
  - 0xFFF4 KCTRL: bit0 RDY, bit2 OVR, bit4 IE; other bits read 0.
  - 0xFFF6 SCTRL: same layout as KCTRL, for switches.
  - 0xFFF8 HEX (R/W, 16 bits).
  - 0xFFFA LEDR (R/W, [9:0]).
  - 0xFFFC LEDG (R/W, [7:0]).
  - All other addresses in the page read 16'hDEAD and ignore writes.
- When `SEL` is low, `RDATA` is don't-care and no state changes from `WE` or `RE`.
- Input path:
  - Each group (KEY inverted, SW) passes through a 2-flop synchronizer.
  - One counter per group counts cycles in which the synchronized vector differs from the debounced vector and equals its previous-cycle value.
  - The counter resets to 0 whenever the synchronized vector changes or equals the debounced vector.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced vector loads the synchronized vector and the counter resets.
- Change event (per group) = the cycle in which the debounced vector loads a new value.
  - Sets RDY.
  - If RDY was already 1 and is not being cleared by a write in the same cycle, it also sets OVR.
- Control register writes:
  - Writing 0 to RDY or OVR clears it; writing 1 leaves it unchanged.
  - IE takes the written value.
- Reading KDATA (or SDATA) with `RE` high clears that group's RDY and OVR at the edge.
- Simultaneous event and clear (by write or read): the event wins, so RDY ends at 1 and OVR ends at 0.
- `IRQ` = (KCTRL.RDY & KCTRL.IE) | (SCTRL.RDY & SCTRL.IE).
- HEX/LEDR/LEDG writes store `WDATA` truncated to the register width; reads return the value zero-extended.

## Timing
- Reset (asynchronous on `RESET_N` low):
  - HEXOUT = 0, LEDR = 0, LEDG = 0.
  - RDY, OVR and IE are 0 in both groups; `IRQ` = 0.
  - Synchronizers and debounced vectors are 0 (keys released, switches 0); counters are 0.
- Release of reset is sampled synchronously, and the first state update occurs on the first rising edge with `RESET_N` high.
- Reset asserted mid-debounce discards the count. Reset asserted during a write discards the write.
- Read latency is 0: `RDATA` is valid in the same cycle `ADDR` is valid.
- Write latency: the register output and `RDATA` reflect the new value after the committing edge.
- Input latency: if a raw change is stable before edge N, the synchronizer output changes at edge N+1 and the debounced vector, RDY and `IRQ` update at edge N+1+`DEBOUNCE_CYCLES`.
- Bounce: any raw change inside the window restarts the count. A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no event.

## Test plan
- Reset: assert `RESET_N`=0 mid-operation → all outputs, RDY/OVR/IE and `IRQ` are 0 asynchronously; KDATA reads 0x0000 and 0xFFFE reads 0xDEAD.
- Outputs: write 0xBEEF to 0xFFF8, 0x3FF to 0xFFFA and 0x1A5 to 0xFFFC → HEXOUT=0xBEEF, LEDR=0x3FF, LEDG=0xA5 the next cycle; reads return 0xBEEF, 0x03FF and 0x00A5.
- Debounce (`DEBOUNCE_CYCLES`=10): drive KEY=4'b1110 stable → KDATA=0x0001 and KCTRL.RDY=1 exactly 11 edges after the first sampling edge. A 9-cycle pulse on SW[3] → no SDATA change and SCTRL.RDY stays 0.
- Sticky/overrun: with KCTRL=0x0010, press and release key 1 without reading → IRQ=1 after the press, OVR=1 after the release. Read KDATA with `RE`=1 → KCTRL reads 0x0010 and IRQ=0.
- Collision: schedule a write of 0x0010 to KCTRL in the same cycle as a debounced key change with RDY=1 → KCTRL reads 0x0011 afterward (RDY=1, OVR=0).

Source files
------------

// File: rtl/mmio_responder_if.sv
// mmio_responder_if: data-memory bus between the processor and the I/O page.
//   addr/wdata/we/re : driven by the processor (master)
//   rdata/sel        : driven by the responder (slave); rdata valid when sel is high
interface mmio_responder_if #(
   parameter int unsigned DBITS = 16
);
   logic [DBITS-1:0] addr;
   logic [DBITS-1:0] wdata;
   logic             we;
   logic             re;
   logic [DBITS-1:0] rdata;
   logic             sel;

   modport master (output addr, output wdata, output we, output re,
                   input  rdata, input sel);
   modport slave  (input  addr, input  wdata, input  we, input  re,
                   output rdata, output sel);
endinterface

// File: rtl/mmio_responder.sv
// mmio_responder_debounce: 2-flop synchronizer plus stability counter for one input group.
//   din  : raw asynchronous vector
//   deb  : debounced vector (registered)
//   ev_c : high in the cycle whose closing edge loads a new debounced value
module mmio_responder_debounce #(
   parameter int unsigned W = 4,
   parameter int unsigned D = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] deb,
   output logic         ev_c
);
   localparam int unsigned CW = (D < 2) ? 1 : $clog2(D);

   logic [W-1:0]  s1, s2, prev;
   logic [CW-1:0] cnt;
   logic [CW-1:0] base_c;

   // A cycle in which the synchronized vector just changed opens a new window and counts as its first.
   always_comb begin
      base_c = (s2 != prev) ? '0 : cnt;
      ev_c   = (s2 != deb) && (base_c == CW'(D - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= '0;
         s2   <= '0;
         prev <= '0;
         deb  <= '0;
         cnt  <= '0;
      end else begin
         s1   <= din;
         s2   <= s1;
         prev <= s2;
         if (s2 == deb) begin
            cnt <= '0;
         end else if (ev_c) begin
            cnt <= '0;
            deb <= s2;
         end else begin
            cnt <= base_c + CW'(1);
         end
      end
   end
endmodule

// mmio_responder: I/O page (0xFFF0-0xFFFF) decoder with key/switch inputs and display outputs.
//   clk, rst_n        : clock, async active-low reset
//   bus               : processor data bus (addr/wdata/we/re in, rdata/sel out)
//   key, sw           : raw board inputs (key active-low)
//   irq               : (KCTRL.RDY & IE) | (SCTRL.RDY & IE)
//   hexout, ledr, ledg: output registers
module mmio_responder #(
   parameter int unsigned DBITS           = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   mmio_responder_if.slave    bus,
   input  logic [3:0]         key,
   input  logic [9:0]         sw,
   output logic               irq,
   output logic [DBITS-1:0]   hexout,
   output logic [9:0]         ledr,
   output logic [7:0]         ledg
);
   localparam logic [2:0] IDX_KDATA = 3'd0;
   localparam logic [2:0] IDX_SDATA = 3'd1;
   localparam logic [2:0] IDX_KCTRL = 3'd2;
   localparam logic [2:0] IDX_SCTRL = 3'd3;
   localparam logic [2:0] IDX_HEX   = 3'd4;
   localparam logic [2:0] IDX_LEDR  = 3'd5;
   localparam logic [2:0] IDX_LEDG  = 3'd6;

   // Control register bits packed as {ie, ovr, rdy}.
   logic [2:0] kctrl_q, sctrl_q, kctrl_d, sctrl_d;
   logic [3:0] kdeb;
   logic [9:0] sdeb;
   logic       k_ev_c, s_ev_c;
   logic       sel_c, wr_c, rd_c;
   logic [2:0] idx_c;
   logic [DBITS-1:0] rdata_c;
   logic       unused_addr0;

   assign unused_addr0 = bus.addr[0];

   mmio_responder_debounce #(.W(4), .D(DEBOUNCE_CYCLES)) u_key_db (
      .clk(clk), .rst_n(rst_n), .din(~key), .deb(kdeb), .ev_c(k_ev_c));

   mmio_responder_debounce #(.W(10), .D(DEBOUNCE_CYCLES)) u_sw_db (
      .clk(clk), .rst_n(rst_n), .din(sw), .deb(sdeb), .ev_c(s_ev_c));

   // Sticky status update; a same-cycle event beats any clear and leaves OVR low if RDY was cleared.
   function automatic logic [2:0] ctrl_next(input logic [2:0] cur, input logic ev,
                                            input logic wr, input logic rdclr,
                                            input logic [DBITS-1:0] wd);
      logic clr_rdy, clr_ovr;
      logic [2:0] nxt;
      nxt     = cur;
      clr_rdy = rdclr | (wr & ~wd[0]);
      clr_ovr = rdclr | (wr & ~wd[2]);
      if (wr)      nxt[2] = wd[4];
      if (clr_rdy) nxt[0] = 1'b0;
      if (clr_ovr) nxt[1] = 1'b0;
      if (ev) begin
         nxt[0] = 1'b1;
         if (clr_rdy)     nxt[1] = 1'b0;
         else if (cur[0]) nxt[1] = 1'b1;
      end
      return nxt;
   endfunction

   // Address decode and read mux.
   always_comb begin
      sel_c   = (bus.addr[DBITS-1:4] == 12'hFFF);
      idx_c   = bus.addr[3:1];
      wr_c    = sel_c & bus.we;
      rd_c    = sel_c & bus.re;
      rdata_c = '0;
      if (sel_c) begin
         case (idx_c)
            IDX_KDATA: rdata_c = DBITS'(kdeb);
            IDX_SDATA: rdata_c = DBITS'(sdeb);
            IDX_KCTRL: rdata_c = DBITS'({kctrl_q[2], 1'b0, kctrl_q[1], 1'b0, kctrl_q[0]});
            IDX_SCTRL: rdata_c = DBITS'({sctrl_q[2], 1'b0, sctrl_q[1], 1'b0, sctrl_q[0]});
            IDX_HEX:   rdata_c = hexout;
            IDX_LEDR:  rdata_c = DBITS'(ledr);
            IDX_LEDG:  rdata_c = DBITS'(ledg);
            default:   rdata_c = DBITS'(16'hDEAD);
         endcase
      end
      kctrl_d = ctrl_next(kctrl_q, k_ev_c, wr_c && (idx_c == IDX_KCTRL),
                          rd_c && (idx_c == IDX_KDATA), bus.wdata);
      sctrl_d = ctrl_next(sctrl_q, s_ev_c, wr_c && (idx_c == IDX_SCTRL),
                          rd_c && (idx_c == IDX_SDATA), bus.wdata);
   end

   assign bus.sel   = sel_c;
   assign bus.rdata = rdata_c;
   assign irq       = (kctrl_q[0] & kctrl_q[2]) | (sctrl_q[0] & sctrl_q[2]);

   // Status and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kctrl_q <= '0;
         sctrl_q <= '0;
         hexout  <= '0;
         ledr    <= '0;
         ledg    <= '0;
      end else begin
         kctrl_q <= kctrl_d;
         sctrl_q <= sctrl_d;
         if (wr_c && (idx_c == IDX_HEX))  hexout <= bus.wdata;
         if (wr_c && (idx_c == IDX_LEDR)) ledr   <= bus.wdata[9:0];
         if (wr_c && (idx_c == IDX_LEDG)) ledg   <= bus.wdata[7:0];
      end
   end
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: scenario tasks for the I/O page responder; expected reads are queued
// on a scoreboard as stimulus is applied and compared when the bus returns data.
module tb_mmio_responder;
   logic        clk;
   logic        rst_n;
   logic [3:0]  key;
   logic [9:0]  sw;
   logic        irq;
   logic [15:0] hexout;
   logic [9:0]  ledr;
   logic [7:0]  ledg;

   mmio_responder_if #(.DBITS(16)) bus ();

   mmio_responder #(.DBITS(16), .DEBOUNCE_CYCLES(10)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .key(key), .sw(sw),
      .irq(irq), .hexout(hexout), .ledr(ledr), .ledg(ledg));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_run  = 0;
   int   n_fail = 0;

   task automatic sb_push(input logic [15:0] a, input logic [15:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   // Read at a falling edge; with r=1 the strobe is held across the next rising edge.
   task automatic rd(input logic [15:0] a, input logic r, output logic [15:0] d);
      @(negedge clk);
      bus.addr = a;
      bus.re   = r;
      #1;
      d = bus.rdata;
      if (r) begin
         @(posedge clk);
         #1;
         bus.re = 1'b0;
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.addr  = a;
      bus.wdata = d;
      bus.we    = 1'b1;
      @(posedge clk);
      #1;
      bus.we    = 1'b0;
   endtask

   task automatic sb_drain();
      exp_t        e;
      logic [15:0] d;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         rd(e.addr, 1'b0, d);
         n_run++;
         if (d !== e.data) begin
            n_fail++;
            $display("FAIL sb_read addr=%h got=%h exp=%h", e.addr, d, e.data);
         end
      end
   endtask

   task automatic test_reset();
      wr(16'hFFF8, 16'h1234);
      wr(16'hFFF4, 16'h0010);
      @(negedge clk);
      bus.addr  = 16'hFFFA;
      bus.wdata = 16'h03FF;
      bus.we    = 1'b1;
      #2 rst_n  = 1'b0;
      #1;
      n_run++;
      if (hexout !== 16'h0000) begin n_fail++; $display("FAIL reset_hexout got=%h exp=0000", hexout); end
      n_run++;
      if (ledr !== 10'h000 || ledg !== 8'h00) begin n_fail++; $display("FAIL reset_leds got=%h/%h exp=0/0", ledr, ledg); end
      n_run++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
      bus.we = 1'b0;
      sb_push(16'hFFF4, 16'h0000);
      sb_push(16'hFFF6, 16'h0000);
      sb_push(16'hFFF0, 16'h0000);
      sb_push(16'hFFF2, 16'h0000);
      sb_push(16'hFFFE, 16'hDEAD);
      sb_drain();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_run++;
      if (ledr !== 10'h000) begin n_fail++; $display("FAIL reset_write_discard got=%h exp=000", ledr); end
   endtask

   task automatic test_outputs();
      wr(16'hFFF8, 16'hBEEF);
      n_run++;
      if (hexout !== 16'hBEEF) begin n_fail++; $display("FAIL hexout got=%h exp=beef", hexout); end
      wr(16'hFFFA, 16'h03FF);
      n_run++;
      if (ledr !== 10'h3FF) begin n_fail++; $display("FAIL ledr got=%h exp=3ff", ledr); end
      wr(16'hFFFD, 16'h01A5);
      n_run++;
      if (ledg !== 8'hA5) begin n_fail++; $display("FAIL ledg got=%h exp=a5", ledg); end
      wr(16'hFFFE, 16'h5555);
      wr(16'h0FF8, 16'h1111);
      n_run++;
      if (bus.sel !== 1'b0) begin n_fail++; $display("FAIL sel_low got=%b exp=0", bus.sel); end
      n_run++;
      if (hexout !== 16'hBEEF) begin n_fail++; $display("FAIL unselected_write got=%h exp=beef", hexout); end
      sb_push(16'hFFF8, 16'hBEEF);
      sb_push(16'hFFFA, 16'h03FF);
      sb_push(16'hFFFC, 16'h00A5);
      sb_push(16'hFFFE, 16'hDEAD);
      sb_drain();
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus.we = 1'b1;
      bus.addr = 16'hFFF8; bus.wdata = 16'h1111;
      @(negedge clk);
      bus.addr = 16'hFFFA; bus.wdata = 16'hFE55;
      @(negedge clk);
      bus.addr = 16'hFFFC; bus.wdata = 16'h12C3;
      @(negedge clk);
      bus.we = 1'b0;
      n_run++;
      if (hexout !== 16'h1111 || ledr !== 10'h255 || ledg !== 8'hC3) begin
         n_fail++;
         $display("FAIL b2b_outputs got=%h/%h/%h exp=1111/255/c3", hexout, ledr, ledg);
      end
      sb_push(16'hFFF8, 16'h1111);
      sb_push(16'hFFFA, 16'h0255);
      sb_push(16'hFFFC, 16'h00C3);
      sb_drain();
   endtask

   task automatic test_debounce();
      logic [15:0] d;
      @(negedge clk);
      key = 4'b1110;
      @(posedge clk);                 // first sampling edge N
      repeat (10) @(posedge clk);     // edge N+10
      rd(16'hFFF0, 1'b0, d);
      n_run++;
      if (d !== 16'h0000) begin n_fail++; $display("FAIL kdata_early got=%h exp=0000", d); end
      @(posedge clk);                 // edge N+11
      sb_push(16'hFFF0, 16'h0001);
      sb_push(16'hFFF4, 16'h0001);
      sb_drain();
      @(negedge clk);
      key = 4'b1111;
      repeat (15) @(negedge clk);
      sb_push(16'hFFF0, 16'h0000);
      sb_push(16'hFFF4, 16'h0005);
      sb_drain();
      rd(16'hFFF0, 1'b1, d);
      sb_push(16'hFFF4, 16'h0000);
      sb_drain();
      // 9-cycle glitch on SW[3]
      @(negedge clk);
      sw = 10'h008;
      repeat (9) @(negedge clk);
      sw = 10'h000;
      repeat (20) @(negedge clk);
      sb_push(16'hFFF2, 16'h0000);
      sb_push(16'hFFF6, 16'h0000);
      sb_drain();
      @(negedge clk);
      sw = 10'h2A5;
      repeat (15) @(negedge clk);
      sb_push(16'hFFF2, 16'h02A5);
      sb_push(16'hFFF6, 16'h0001);
      sb_drain();
      n_run++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked got=%b exp=0", irq); end
   endtask

   task automatic test_sticky();
      logic [15:0] d;
      wr(16'hFFF4, 16'h0010);
      @(negedge clk);
      key = 4'b1101;
      repeat (15) @(negedge clk);
      n_run++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_press got=%b exp=1", irq); end
      sb_push(16'hFFF0, 16'h0002);
      sb_push(16'hFFF4, 16'h0011);
      sb_drain();
      @(negedge clk);
      key = 4'b1111;
      repeat (15) @(negedge clk);
      sb_push(16'hFFF0, 16'h0000);
      sb_push(16'hFFF4, 16'h0015);
      sb_drain();
      rd(16'hFFF0, 1'b1, d);
      sb_push(16'hFFF4, 16'h0010);
      sb_drain();
      n_run++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared got=%b exp=0", irq); end
   endtask

   task automatic test_collision();
      logic [15:0] d;
      @(negedge clk);
      key = 4'b1110;
      repeat (15) @(negedge clk);
      sb_push(16'hFFF4, 16'h0011);
      sb_drain();
      // Release lands its event on edge N+11, the same edge as the KCTRL write.
      @(negedge clk);
      key = 4'b1111;
      @(posedge clk);
      repeat (10) @(posedge clk);
      wr(16'hFFF4, 16'h0010);
      sb_push(16'hFFF4, 16'h0011);
      sb_push(16'hFFF0, 16'h0000);
      sb_drain();
      n_run++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_collision got=%b exp=1", irq); end
      // Switch event coinciding with a clearing SDATA read.
      @(negedge clk);
      sw = 10'h000;
      @(posedge clk);
      repeat (10) @(posedge clk);
      rd(16'hFFF2, 1'b1, d);
      n_run++;
      if (d !== 16'h02A5) begin n_fail++; $display("FAIL sdata_before_event got=%h exp=02a5", d); end
      sb_push(16'hFFF6, 16'h0001);
      sb_push(16'hFFF2, 16'h0000);
      sb_drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      key       = 4'hF;
      sw        = 10'h000;
      bus.addr  = 16'h0000;
      bus.wdata = 16'h0000;
      bus.we    = 1'b0;
      bus.re    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_outputs();
      test_back_to_back();
      test_debounce();
      test_sticky();
      test_collision();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
